benes_route_ctrl: RTL

Configuration controller for the Benes permutation network built from 2x2 switch cells. It holds a small table of precomputed routing patterns, one control bit per switch, and accepts permutation requests through a valid/ready handshake. For each request it drives the switch-control bus with the selected pattern, gates a fixed number of data beats through the network, and waits for the network pipeline to drain before allowing reconfiguration. It sits between the interconnect scheduler and the switch array; data itself does not pass through this block.

---
 rtl/benes_route_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/benes_route_ctrl.sv
// Routing-table controller for a Benes network of 2x2 switches: it stores
// per-stage switch patterns, applies one on request, meters the data beats and waits for the network to drain.
module benes_route_ctrl #(
  parameter int unsigned LOG_N    = 3,
  parameter int unsigned NUM_PERM = 4,
  parameter int unsigned BEAT_W   = 8,
  parameter int unsigned PIPE_LAT = 0,
  localparam int unsigned N       = 2 ** LOG_N,
  localparam int unsigned STAGES  = 2 * LOG_N - 1,
  localparam int unsigned SPS     = N / 2,
  localparam int unsigned PW      = (NUM_PERM > 1) ? $clog2(NUM_PERM) : 1,
  localparam int unsigned SW      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_wr_en,
  input  logic [PW-1:0]           cfg_wr_perm,
  input  logic [SW-1:0]           cfg_wr_stage,
  input  logic [SPS-1:0]          cfg_wr_data,
  output logic                    cfg_wr_err,
  input  logic                    req_valid,
  input  logic [PW-1:0]           req_perm,
  input  logic [BEAT_W-1:0]       req_beats,
  output logic                    req_ready,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [STAGES*SPS-1:0]   sw_set,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned TW        = STAGES * SPS;
  localparam int unsigned DRAIN_CYC = (PIPE_LAT > 1) ? PIPE_LAT : 1;
  localparam int unsigned DW        = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     cur_perm;
  logic [BEAT_W-1:0] cur_beats;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_cnt_inc;
  logic [DW-1:0]     drain_cnt;
  logic [TW-1:0]     route_tbl [NUM_PERM];

  logic wr_ok, req_acc, beat_acc, last_beat, drain_start, drain_end;

  assign req_ready = (state == IDLE);
  assign in_ready  = (state == RUN);
  assign busy      = (state != IDLE);

  always_comb begin
    wr_ok        = cfg_wr_en
                   && (32'(cfg_wr_stage) < STAGES)
                   && (32'(cfg_wr_perm) < NUM_PERM)
                   && ((state == IDLE) || (cfg_wr_perm != cur_perm));
    req_acc      = (state == IDLE) && req_valid;
    beat_acc     = (state == RUN) && in_valid;
    beat_cnt_inc = beat_cnt + 1'b1;
    last_beat    = beat_acc && (beat_cnt_inc == cur_beats);
    drain_start  = ((state == LOAD) && (cur_beats == '0)) || last_beat;
    drain_end    = (state == DRAIN) && (drain_cnt == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_acc) state_nxt = LOAD;
      LOAD:    state_nxt = (cur_beats != '0) ? RUN : DRAIN;
      RUN:     if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_wr_err <= 1'b0;
      done       <= 1'b0;
      cur_perm   <= '0;
      cur_beats  <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      sw_set     <= '0;
      for (int unsigned i = 0; i < NUM_PERM; i++) route_tbl[i] <= '0;
    end else begin
      cfg_wr_err <= cfg_wr_en && !wr_ok;
      done       <= drain_end;
      // Row write precedes the LOAD read by a cycle, so a same-cycle write+request sees the new row.
      if (wr_ok) route_tbl[cfg_wr_perm][cfg_wr_stage*SPS +: SPS] <= cfg_wr_data;
      if (req_acc) begin
        cur_perm  <= req_perm;
        cur_beats <= req_beats;
        beat_cnt  <= '0;
      end
      if (state == LOAD) begin
        if (32'(cur_perm) < NUM_PERM) sw_set <= route_tbl[cur_perm];
        else                          sw_set <= '0;
      end
      if (beat_acc) beat_cnt <= beat_cnt_inc;
      if (drain_start)                             drain_cnt <= DW'(DRAIN_CYC - 1);
      else if ((state == DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - 1'b1;
    end
  end

endmodule
